trace_scheduler: RTL and testbench
==================================

Name: trace_scheduler

Overview:
- Sequences the column tracer across all screen columns during VBLANK and commits each result to the trace buffer.
- Sits between the frame timing (vblank from vga_sync), the tracer core (start/done handshake), and the trace buffer write port.
- Owns buffer write-enable, address and data during VBLANK.
- Aborts cleanly if VBLANK ends before all columns are traced.

Parameters:
- NUM_COLS, 640, number of columns traced per frame (0..NUM_COLS-1).
- COL_W, 10, width of column index.
- HEIGHT_W, 8, width of wall height result.
- TIMEOUT, 1023, per-column watchdog limit in cycles waiting for trace_done.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- vblank  in  1  high while not rendering (v >= 480).
- enable  in  1  sampled at vblank rise; low = skip this frame's trace.
- trace_start  out  1  one-cycle pulse: tracer begins column trace_col.
- trace_col  out  COL_W  column index presented to tracer; held stable until trace_done.
- trace_abort  out  1  one-cycle pulse: tracer must drop the current column.
- trace_done  in  1  one-cycle pulse from tracer; trace_side/trace_height valid this cycle.
- trace_side  in  1  wall side result.
- trace_height  in  HEIGHT_W  wall height result.
- buf_we  out  1  trace buffer write enable.
- buf_addr  out  COL_W  trace buffer column address.
- buf_side  out  1  side written.
- buf_height  out  HEIGHT_W  height written.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse after the last column is stored.
- overrun  out  1  sticky: VBLANK ended mid-trace; cleared only by reset.
- timeout  out  1  sticky: a watchdog expiry occurred; cleared only by reset.

Behaviour:
- Reset: state IDLE, col=0, all outputs 0, vblank_q=0, watchdog=0.
- vblank_q registers vblank; rise = vblank & ~vblank_q.
- IDLE:
  - On rise with enable=1: col<=0, go ISSUE.
  - On rise with enable=0: stay IDLE, no tracer activity.
  - Rise is not re-armed until the next frame.
- ISSUE: trace_start=1 for exactly one cycle, trace_col=col, watchdog<=0, go WAIT.
- WAIT:
  - On trace_done: latch side/height, go STORE.
  - Otherwise watchdog+1. When watchdog==TIMEOUT: latch side=0, height=0 (renders as dead column), set timeout, pulse trace_abort, go STORE.
- STORE: buf_we=1 for one cycle with buf_addr=col and latched data.
  - If col==NUM_COLS-1: pulse frame_done next cycle, go IDLE.
  - Else col<=col+1, go ISSUE.
- Timing per column: start at cycle t, done at t+k (k>=1), buf_we at t+k+1, next start at t+k+2.
- buf_we is 0 in all states except STORE.
- VBLANK end: vblank sampled low in ISSUE, WAIT or STORE gives:
  - no buf_we that cycle;
  - trace_abort pulses if a trace is outstanding (WAIT, or ISSUE after start);
  - overrun set, go IDLE.
  - Columns >= col keep stale buffer data.
- trace_done outside WAIT: ignored.
- trace_done on the same cycle as watchdog expiry: done wins, no timeout.
- Reset mid-operation: immediate return to IDLE, no buf_we, no trace_abort.
- trace_col holds its value between columns; buf_addr/buf_side/buf_height hold their last values when buf_we=0.

Optional Feature:
- Macro TRACE_PERF_EN.
- Defined: adds output perf_cycles [15:0], which counts cycles from ISSUE of column 0 to frame_done.
  - Counter saturates at 16'hFFFF.
  - Value is latched on frame_done and holds until the next frame_done.
  - Reset value 0; an aborted frame does not update it.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Tracer model with k=3, NUM_COLS=4, enable=1, vblank rises and stays high: 4 buf_we pulses, addr 0,1,2,3, each 5 cycles apart; frame_done 1 cycle after last we; overrun=0.
- enable=0 at vblank rise: no trace_start, no buf_we, busy=0 for the whole frame.
- Tracer never returns done for col 2, TIMEOUT=15: trace_abort 16 cycles after start; buf_we addr=2 with side=0, height=0; timeout=1; col 3 proceeds normally.
- vblank drops while in WAIT on col 1: trace_abort pulse, no buf_we for col 1, overrun=1, busy=0 next cycle; next vblank rise restarts at col 0.
- Spurious trace_done in IDLE/STORE plus reset asserted during WAIT: no extra buf_we, all outputs 0 the cycle after reset.
- TRACE_PERF_EN, k=3, NUM_COLS=4: perf_cycles=20 after frame_done.

Source files
------------

// File: rtl/trace_scheduler_if.sv
// Tracer handshake and trace-buffer write port seen by trace_scheduler.
// master = scheduler side, slave = tracer core / buffer side.
interface trace_scheduler_if #(
  parameter int unsigned COL_W    = 10,
  parameter int unsigned HEIGHT_W = 8
);
  logic                trace_start;
  logic [COL_W-1:0]    trace_col;
  logic                trace_abort;
  logic                trace_done;
  logic                trace_side;
  logic [HEIGHT_W-1:0] trace_height;
  logic                buf_we;
  logic [COL_W-1:0]    buf_addr;
  logic                buf_side;
  logic [HEIGHT_W-1:0] buf_height;

  modport master (
    output trace_start, trace_col, trace_abort, buf_we, buf_addr, buf_side, buf_height,
    input  trace_done, trace_side, trace_height
  );

  modport slave (
    input  trace_start, trace_col, trace_abort, buf_we, buf_addr, buf_side, buf_height,
    output trace_done, trace_side, trace_height
  );
endinterface

// File: rtl/trace_scheduler.sv
// Walks the column tracer over every column during VBLANK and stores results in the trace buffer.
// Optional TRACE_PERF_EN adds perf_cycles: cycles from column 0 issue to frame_done.
module trace_scheduler #(
  parameter int unsigned NUM_COLS = 640,
  parameter int unsigned COL_W    = 10,
  parameter int unsigned HEIGHT_W = 8,
  parameter int unsigned TIMEOUT  = 1023
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 vblank,
  input  logic                 enable,
  trace_scheduler_if.master    bus,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overrun,
  output logic                 timeout
`ifdef TRACE_PERF_EN
  ,
  output logic [15:0]          perf_cycles
`endif
);
  localparam int unsigned WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [COL_W-1:0] LastCol = COL_W'(NUM_COLS - 1);
  localparam logic [WD_W-1:0]  WdMax   = WD_W'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StStore} state_e;

  state_e              state_q, state_d;
  logic                vblank_q, rise;
  logic [COL_W-1:0]    col_q, col_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic                side_q, side_d;
  logic [HEIGHT_W-1:0] height_q, height_d;
  logic [COL_W-1:0]    addr_hold_q;
  logic                side_hold_q;
  logic [HEIGHT_W-1:0] height_hold_q;
  logic                frame_done_q, frame_done_d;
  logic                overrun_q, overrun_d;
  logic                timeout_q, timeout_d;

  assign rise = vblank & ~vblank_q;

  always_comb begin
    state_d         = state_q;
    col_d           = col_q;
    wd_d            = wd_q;
    side_d          = side_q;
    height_d        = height_q;
    frame_done_d    = 1'b0;
    overrun_d       = overrun_q;
    timeout_d       = timeout_q;
    bus.trace_start = 1'b0;
    bus.trace_abort = 1'b0;
    bus.buf_we      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rise && enable) begin
          col_d   = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (!vblank) begin
          overrun_d = 1'b1;
          state_d   = StIdle;
        end else begin
          bus.trace_start = 1'b1;
          wd_d            = '0;
          state_d         = StWait;
        end
      end
      StWait: begin
        if (!vblank) begin
          bus.trace_abort = 1'b1;
          overrun_d       = 1'b1;
          state_d         = StIdle;
        end else if (bus.trace_done) begin
          side_d   = bus.trace_side;
          height_d = bus.trace_height;
          state_d  = StStore;
        end else if (wd_q == WdMax) begin
          // Dead column: store zeros so the renderer draws nothing here.
          side_d          = 1'b0;
          height_d        = '0;
          timeout_d       = 1'b1;
          bus.trace_abort = 1'b1;
          state_d         = StStore;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      StStore: begin
        if (!vblank) begin
          overrun_d = 1'b1;
          state_d   = StIdle;
        end else begin
          bus.buf_we = 1'b1;
          if (col_q == LastCol) begin
            frame_done_d = 1'b1;
            state_d      = StIdle;
          end else begin
            col_d   = col_q + COL_W'(1);
            state_d = StIssue;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Reset wins over everything the current state would drive this cycle.
    if (reset) begin
      bus.trace_start = 1'b0;
      bus.trace_abort = 1'b0;
      bus.buf_we      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      vblank_q      <= 1'b0;
      col_q         <= '0;
      wd_q          <= '0;
      side_q        <= 1'b0;
      height_q      <= '0;
      addr_hold_q   <= '0;
      side_hold_q   <= 1'b0;
      height_hold_q <= '0;
      frame_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      vblank_q      <= vblank;
      col_q         <= col_d;
      wd_q          <= wd_d;
      side_q        <= side_d;
      height_q      <= height_d;
      addr_hold_q   <= bus.buf_addr;
      side_hold_q   <= bus.buf_side;
      height_hold_q <= bus.buf_height;
      frame_done_q  <= frame_done_d;
      overrun_q     <= overrun_d;
      timeout_q     <= timeout_d;
    end
  end

  // Buffer port shows the live write only while buf_we is high, else the last write.
  assign bus.trace_col  = col_q;
  assign bus.buf_addr   = bus.buf_we ? col_q    : addr_hold_q;
  assign bus.buf_side   = bus.buf_we ? side_q   : side_hold_q;
  assign bus.buf_height = bus.buf_we ? height_q : height_hold_q;
  assign busy           = (state_q != StIdle);
  assign frame_done     = frame_done_q;
  assign overrun        = overrun_q;
  assign timeout        = timeout_q;

`ifdef TRACE_PERF_EN
  logic [15:0] perf_cnt_q, perf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cnt_q <= '0;
      perf_q     <= '0;
    end else begin
      if (state_q == StIdle) begin
        perf_cnt_q <= '0;
      end else if (perf_cnt_q != 16'hFFFF) begin
        perf_cnt_q <= perf_cnt_q + 16'd1;
      end
      if (frame_done_d) begin
        perf_q <= (perf_cnt_q == 16'hFFFF) ? 16'hFFFF : perf_cnt_q + 16'd1;
      end
    end
  end

  assign perf_cycles = perf_q;
`endif
endmodule

// File: tb/tb_trace_scheduler.sv
// Directed frames with a randomized-latency tracer model; expected buffer writes and timing
// come from per-column durations and the results the tracer model handed out.
module tb_trace_scheduler;
  localparam int unsigned NC = 4;
  localparam int unsigned CW = 10;
  localparam int unsigned HW = 8;
  localparam int unsigned TO = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic vblank = 1'b0;
  logic enable = 1'b0;
  logic busy, frame_done, overrun, timeout;
`ifdef TRACE_PERF_EN
  logic [15:0] perf_cycles;
`endif

  int total = 0;
  int bad = 0;

  trace_scheduler_if #(.COL_W(CW), .HEIGHT_W(HW)) bus ();

  trace_scheduler #(
    .NUM_COLS(NC), .COL_W(CW), .HEIGHT_W(HW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .vblank(vblank), .enable(enable), .bus(bus),
    .busy(busy), .frame_done(frame_done), .overrun(overrun), .timeout(timeout)
`ifdef TRACE_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {int t; int addr; int side; int height;} wr_t;
  typedef struct {int col; int side; int height;} res_t;

  wr_t  wq[$];
  res_t rq[$];
  int   start_t[$];
  int   start_c[$];
  int   abort_t[$];
  int   fd_t[$];
  int   busy_cnt = 0;
  int   ncyc = 0;

  // Tracer model knobs
  int k = 3;
  int hang_col = -1;
  bit dbl = 1'b0;
  bit spur = 1'b0;
  bit pending = 1'b0;
  bit dbl_left = 1'b0;
  int start_n = 0;
  int cur_col = 0;

  // Monitor first (DUT outputs settled), then tracer model drives its inputs.
  always @(negedge clk) begin
    ncyc++;
    if (bus.buf_we === 1'b1)
      wq.push_back('{ncyc, int'(bus.buf_addr), int'(bus.buf_side), int'(bus.buf_height)});
    if (bus.trace_start === 1'b1) begin
      start_t.push_back(ncyc);
      start_c.push_back(int'(bus.trace_col));
    end
    if (bus.trace_abort === 1'b1) abort_t.push_back(ncyc);
    if (frame_done === 1'b1) fd_t.push_back(ncyc);
    if (busy !== 1'b0) busy_cnt++;

    bus.trace_done = 1'b0;
    if (dbl_left) begin
      bus.trace_done = 1'b1;
      dbl_left = 1'b0;
    end
    if (spur) bus.trace_done = 1'b1;
    if (pending && ncyc == start_n + k) begin
      pending = 1'b0;
      bus.trace_done   = 1'b1;
      bus.trace_side   = 1'($urandom);
      bus.trace_height = 8'($urandom);
      rq.push_back('{cur_col, int'(bus.trace_side), int'(bus.trace_height)});
      dbl_left = dbl;
    end
    if (bus.trace_start === 1'b1) begin
      pending = (int'(bus.trace_col) != hang_col);
      start_n = ncyc;
      cur_col = int'(bus.trace_col);
    end
    if (bus.trace_abort === 1'b1 || reset) pending = 1'b0;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_fd(input string nm, input int n0, input int budget);
    int i;
    i = 0;
    while (fd_t.size() <= n0 && i < budget) begin
      step(1);
      i++;
    end
    check({nm, "_frame_done_seen"}, 64'(fd_t.size() > n0), 64'd1);
  endtask

  // Raise vblank; returns the negedge index of the rise cycle.
  task automatic raise(output int rise_n);
    vblank = 1'b1;
    rise_n = ncyc + 1;
  endtask

  task automatic check_frame(input string nm, input int w0, input int s0, input int r0,
                             input int a0, input int kk, input int hang, input int rise_n);
    int t, ri, dur, sum, es, eh;
    t = rise_n + 1;
    ri = r0;
    sum = 0;
    check({nm, "_starts"}, 64'(start_t.size() - s0), 64'(NC));
    check({nm, "_writes"}, 64'(wq.size() - w0), 64'(NC));
    if (start_t.size() - s0 < NC || wq.size() - w0 < NC || fd_t.size() == 0) return;
    for (int c = 0; c < NC; c++) begin
      dur = (c == hang) ? TO + 3 : kk + 2;
      check({nm, "_start_time"}, 64'(start_t[s0 + c]), 64'(t));
      check({nm, "_start_col"}, 64'(start_c[s0 + c]), 64'(c));
      check({nm, "_we_time"}, 64'(wq[w0 + c].t), 64'(t + dur - 1));
      check({nm, "_we_addr"}, 64'(wq[w0 + c].addr), 64'(c));
      if (c == hang) begin
        es = 0;
        eh = 0;
        check({nm, "_abort_time"}, 64'((abort_t.size() > a0) ? abort_t[a0] : -1), 64'(t + TO + 1));
      end else begin
        es = (ri < rq.size()) ? rq[ri].side : -1;
        eh = (ri < rq.size()) ? rq[ri].height : -1;
        ri++;
      end
      check({nm, "_we_side"}, 64'(wq[w0 + c].side), 64'(es));
      check({nm, "_we_height"}, 64'(wq[w0 + c].height), 64'(eh));
      t += dur;
      sum += dur;
    end
    check({nm, "_frame_done_time"}, 64'(fd_t[fd_t.size() - 1]), 64'(t));
`ifdef TRACE_PERF_EN
    check({nm, "_perf_cycles"}, 64'(perf_cycles), 64'(sum));
`endif
  endtask

  initial begin
    int w0, s0, r0, a0, f0, b0, rn, kk;

    // Reset state
    step(3);
    reset = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_trace_start", 64'(bus.trace_start), 64'd0);
    check("rst_trace_abort", 64'(bus.trace_abort), 64'd0);
    check("rst_trace_col", 64'(bus.trace_col), 64'd0);
    check("rst_buf_we", 64'(bus.buf_we), 64'd0);
    check("rst_buf_addr", 64'(bus.buf_addr), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
`ifdef TRACE_PERF_EN
    check("rst_perf", 64'(perf_cycles), 64'd0);
`endif
    step(2);

    // Frame 1: k=3, full frame
    k = 3; enable = 1'b1;
    w0 = wq.size(); s0 = start_t.size(); r0 = rq.size(); a0 = abort_t.size(); f0 = fd_t.size();
    raise(rn);
    wait_fd("f1", f0, 200);
    check_frame("f1", w0, s0, r0, a0, 3, -1, rn);
    check("f1_overrun", 64'(overrun), 64'd0);
    check("f1_timeout", 64'(timeout), 64'd0);
    check("f1_aborts", 64'(abort_t.size() - a0), 64'd0);
    step(2);
    vblank = 1'b0;
    step(3);

    // Frame 2: enable=0 at rise, nothing happens
    enable = 1'b0;
    w0 = wq.size(); s0 = start_t.size(); b0 = busy_cnt;
    raise(rn);
    step(40);
    check("f2_starts", 64'(start_t.size() - s0), 64'd0);
    check("f2_writes", 64'(wq.size() - w0), 64'd0);
    check("f2_busy", 64'(busy_cnt - b0), 64'd0);
    enable = 1'b1;
    step(5);
    check("f2_no_rearm", 64'(start_t.size() - s0), 64'd0);
    vblank = 1'b0;
    step(3);

    // Frame 3: column 2 never completes -> watchdog
    kk = int'($urandom_range(1, 4)); k = kk; hang_col = 2;
    w0 = wq.size(); s0 = start_t.size(); r0 = rq.size(); a0 = abort_t.size(); f0 = fd_t.size();
    raise(rn);
    wait_fd("f3", f0, 300);
    check_frame("f3", w0, s0, r0, a0, kk, 2, rn);
    check("f3_timeout", 64'(timeout), 64'd1);
    check("f3_overrun", 64'(overrun), 64'd0);
    check("f3_aborts", 64'(abort_t.size() - a0), 64'd1);
    hang_col = -1;
    step(2);
    vblank = 1'b0;
    step(3);

    // Frame 4: vblank ends while waiting on column 1
    k = 8;
    w0 = wq.size(); s0 = start_t.size(); a0 = abort_t.size(); f0 = fd_t.size();
    raise(rn);
    for (int i = 0; i < 100 && start_t.size() < s0 + 2; i++) step(1);
    check("f4_col1_started", 64'(start_t.size() - s0), 64'd2);
    vblank = 1'b0;
    step(1);
    check("f4_busy", 64'(busy), 64'd0);
    check("f4_overrun", 64'(overrun), 64'd1);
    check("f4_writes", 64'(wq.size() - w0), 64'd1);
    check("f4_aborts", 64'(abort_t.size() - a0), 64'd1);
    if (abort_t.size() > a0 && start_t.size() > s0 + 1)
      check("f4_abort_time", 64'(abort_t[a0]), 64'(start_t[s0 + 1] + 1));
    check("f4_no_frame_done", 64'(fd_t.size() - f0), 64'd0);
    step(3);
    kk = int'($urandom_range(1, 4)); k = kk;
    w0 = wq.size(); s0 = start_t.size(); r0 = rq.size(); a0 = abort_t.size(); f0 = fd_t.size();
    raise(rn);
    wait_fd("f4r", f0, 200);
    check_frame("f4r", w0, s0, r0, a0, kk, -1, rn);
    check("f4r_overrun_sticky", 64'(overrun), 64'd1);
    check("f4r_timeout_sticky", 64'(timeout), 64'd1);
    step(2);
    vblank = 1'b0;
    step(3);

    // Frame 5: spurious done in IDLE and STORE, then reset during WAIT
    w0 = wq.size(); s0 = start_t.size();
    spur = 1'b1;
    step(2);
    spur = 1'b0;
    step(2);
    check("f5_idle_spur_writes", 64'(wq.size() - w0), 64'd0);
    check("f5_idle_spur_starts", 64'(start_t.size() - s0), 64'd0);
    k = 3; dbl = 1'b1; a0 = abort_t.size();
    raise(rn);
    for (int i = 0; i < 100 && start_t.size() < s0 + 2; i++) step(1);
    check("f5_col1_started", 64'(start_t.size() - s0), 64'd2);
    enable = 1'b0;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    dbl = 1'b0;
    check("f5_writes", 64'(wq.size() - w0), 64'd1);
    if (wq.size() > w0) check("f5_we_addr", 64'(wq[w0].addr), 64'd0);
    check("f5_aborts", 64'(abort_t.size() - a0), 64'd0);
    check("f5_busy", 64'(busy), 64'd0);
    check("f5_trace_start", 64'(bus.trace_start), 64'd0);
    check("f5_trace_abort", 64'(bus.trace_abort), 64'd0);
    check("f5_trace_col", 64'(bus.trace_col), 64'd0);
    check("f5_buf_we", 64'(bus.buf_we), 64'd0);
    check("f5_buf_addr", 64'(bus.buf_addr), 64'd0);
    check("f5_buf_side", 64'(bus.buf_side), 64'd0);
    check("f5_buf_height", 64'(bus.buf_height), 64'd0);
    check("f5_overrun", 64'(overrun), 64'd0);
    check("f5_timeout", 64'(timeout), 64'd0);
    check("f5_frame_done", 64'(frame_done), 64'd0);
    b0 = busy_cnt; s0 = start_t.size();
    step(6);
    check("f5_post_busy", 64'(busy_cnt - b0), 64'd0);
    check("f5_post_starts", 64'(start_t.size() - s0), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit observed=expired expected=finished");
    $fatal(1, "time limit");
  end
endmodule
